// File: rtl/reg_writeback_arbiter.sv
// Register-file write-port arbiter: ALU results (priority) merged with buffered LSU results,
// plus a pending-destination scoreboard. Define WB_BYPASS_EN for the 1-cycle LSU bypass.
module reg_writeback_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned PtrW      = $clog2(FIFO_DEPTH),
  localparam int unsigned CntW      = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            alu_valid_i,
  input  logic [4:0]      alu_rd_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic            lsu_valid_i,
  output logic            lsu_ready_o,
  input  logic [4:0]      lsu_rd_i,
  input  logic [XLEN-1:0] lsu_data_i,
  input  logic            issue_valid_i,
  input  logic [4:0]      issue_rd_i,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  output logic            rs1_busy_o,
  output logic            rs2_busy_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] rd_din_o,
  output logic            reg_write_o,
  output logic [CntW-1:0] fifo_count_o
);

  logic [XLEN-1:0] data_mem [FIFO_DEPTH];
  logic [4:0]      rd_mem   [FIFO_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     pending_q, pending_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] din_q, din_d;
  logic            we_q, we_d;

  logic            push, fifo_push, pop, bypass, fifo_empty;
  logic            lsu_load;
  logic [4:0]      lsu_load_rd;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;

  // Ready depends only on occupancy, so a full FIFO never passes through on a same-cycle pop.
  assign lsu_ready_o  = ~rst_i & (count_q < CntW'(FIFO_DEPTH));
  assign fifo_count_o = count_q;
  assign rd_o         = rd_q;
  assign rd_din_o     = din_q;
  assign reg_write_o  = we_q;
  assign rs1_busy_o   = pending_q[rs1_i] & (rs1_i != 5'd0);
  assign rs2_busy_o   = pending_q[rs2_i] & (rs2_i != 5'd0);

  assign head_rd   = rd_mem[rd_ptr_q];
  assign head_data = data_mem[rd_ptr_q];

  always_comb begin
    push       = lsu_valid_i & lsu_ready_o;
    fifo_empty = (count_q == '0);
    pop        = ~alu_valid_i & ~fifo_empty;
`ifdef WB_BYPASS_EN
    bypass     = ~alu_valid_i & fifo_empty & push;
`else
    bypass     = 1'b0;
`endif
    fifo_push  = push & ~bypass;
  end

  always_comb begin
    rd_d        = rd_q;
    din_d       = din_q;
    we_d        = 1'b0;
    lsu_load    = 1'b0;
    lsu_load_rd = '0;
    if (alu_valid_i) begin
      rd_d  = alu_rd_i;
      din_d = alu_data_i;
      we_d  = (alu_rd_i != 5'd0);
    end else if (pop) begin
      rd_d        = head_rd;
      din_d       = head_data;
      we_d        = (head_rd != 5'd0);
      lsu_load    = 1'b1;
      lsu_load_rd = head_rd;
    end else if (bypass) begin
      rd_d        = lsu_rd_i;
      din_d       = lsu_data_i;
      we_d        = (lsu_rd_i != 5'd0);
      lsu_load    = 1'b1;
      lsu_load_rd = lsu_rd_i;
    end
  end

  always_comb begin
    wr_ptr_d = fifo_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    unique case ({fifo_push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Set after clear so a same-cycle re-issue keeps the bit pending.
  always_comb begin
    pending_d = pending_q;
    if (lsu_load) pending_d[lsu_load_rd] = 1'b0;
    if (issue_valid_i && (issue_rd_i != 5'd0)) pending_d[issue_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      rd_q      <= '0;
      din_q     <= '0;
      we_q      <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      rd_q      <= rd_d;
      din_q     <= din_d;
      we_q      <= we_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_push) begin
      data_mem[wr_ptr_q] <= lsu_data_i;
      rd_mem[wr_ptr_q]   <= lsu_rd_i;
    end
  end

endmodule
